// File: rtl/weight_bank_pkg.sv
// Shared types and constants for the convolution weight banks.
// Pure definitions; no logic.
// No handshake.
package weight_bank_pkg;

    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned AW_DEFAULT = 10;

    typedef logic half_t;

    function automatic int unsigned tile_cap(input int unsigned tn, input int unsigned tm,
                                             input int unsigned k, input int unsigned x,
                                             input int unsigned y);
        return (tn / y) * (tm / x) * k * k;
    endfunction

endpackage

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered address and output.
// Read data appears two edges after re; a colliding write returns the old word.
// No backpressure; oe holds rdata when no response is due.
module simple_dp_ram #(
    parameter int unsigned DEPTH = 288,
    parameter int unsigned AW    = 9,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    input  logic          oe,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] raddr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Contents are never cleared; only the read path carries reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raddr_q <= '0;
            rdata   <= '0;
        end else begin
            if (re) begin
                raddr_q <= raddr;
            end
            if (oe) begin
                rdata <= mem[raddr_q];
            end
        end
    end

endmodule

// File: rtl/weight_bank_pingpong.sv
// Double-buffered weight bank: load one half while the PE array reads the other.
// Read latency 2 cycles, fully pipelined; load accepts one word per cycle.
// wr_ready drops while both halves are full, returning the cycle after rd_release.
module weight_bank_pingpong
    import weight_bank_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT,
    parameter int unsigned DW = DW_DEFAULT,
    parameter int unsigned Tn = 16,
    parameter int unsigned Tm = 16,
    parameter int unsigned K  = 3,
    parameter int unsigned X  = 4,
    parameter int unsigned Y  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    output logic [AW-1:0] wr_count,
    output logic          rd_tile_valid,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_data_valid,
    input  logic          rd_release,
    output logic          rd_err
);

    localparam int unsigned CAP   = tile_cap(Tn, Tm, K, X, Y);
    localparam int unsigned DEPTH = 2 * CAP;
    localparam int unsigned RAW   = $clog2(DEPTH);

    // Halves are packed back to back so the RAM is exactly two tiles deep.
    function automatic logic [RAW-1:0] phys_addr(input half_t h, input logic [AW-1:0] a);
        return RAW'(a) + (h ? RAW'(CAP) : RAW'(0));
    endfunction

    logic [1:0]    full;
    logic [1:0]    full_nxt;
    half_t         wr_sel;
    half_t         rd_sel;
    logic [AW-1:0] wr_cnt;
    logic          rd_vld_s1;
    logic          wr_fire;
    logic          wr_last;
    logic          rd_ok;
    logic          rel;

    assign wr_ready      = !full[wr_sel];
    assign wr_count      = wr_cnt;
    assign rd_tile_valid = full[rd_sel];

    assign wr_fire = wr_valid && wr_ready && !flush;
    assign wr_last = wr_fire && (32'(wr_cnt) == CAP - 1);
    assign rd_ok   = rd_en && rd_tile_valid && (32'(rd_addr) < CAP) && !flush;
    assign rel     = rd_release && rd_tile_valid && !flush;

    // Filling and releasing always touch different halves, so both may land together.
    always_comb begin
        full_nxt = full;
        if (wr_last) begin
            full_nxt[wr_sel] = 1'b1;
        end
        if (rel) begin
            full_nxt[rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full          <= 2'b00;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
            wr_cnt        <= '0;
            rd_vld_s1     <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_err        <= 1'b0;
        end else if (flush) begin
            full          <= 2'b00;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
            wr_cnt        <= '0;
            rd_vld_s1     <= 1'b0;
            rd_data_valid <= 1'b0;
            rd_err        <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + AW'(1);
            end
            if (wr_last) begin
                wr_sel <= ~wr_sel;
            end
            if (rel) begin
                rd_sel <= ~rd_sel;
            end
            rd_vld_s1     <= rd_ok;
            rd_data_valid <= rd_vld_s1;
            if (rd_en && !rd_ok) begin
                rd_err <= 1'b1;
            end
        end
    end

    // The half is folded into the captured address, so in-flight reads survive a release.
    simple_dp_ram #(
        .DEPTH (DEPTH),
        .AW    (RAW),
        .DW    (DW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr (phys_addr(wr_sel, wr_cnt)),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (phys_addr(rd_sel, rd_addr)),
        .oe    (rd_vld_s1 && !flush),
        .rdata (rd_data)
    );

endmodule
